pipe_mac_mul: RTL and testbench

Parametrised, fully pipelined N x N multiplier with optional accumulate, selectable signed/unsigned operands and valid/ready flow control on both sides. It is the next generation of the team's fixed 3-stage unsigned multiplier. It adds configurable pipeline depth, backpressure, a MAC mode and a wide accumulator. It sits between a streaming operand source and a result consumer in DSP/filter datapaths.

---
 rtl/pipe_mac_mul.sv | 148 ++++++++++++++
 tb/tb_pipe_mac_mul.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mac_mul.sv
`timescale 1ns/1ps
// pipe_mac_mul: pipelined N x N multiplier with an optional wide accumulator.
// Operands can be signed or unsigned, chosen per beat.
// Valid/ready flow control: the whole pipe advances or freezes as one.
// Stage 1 registers the operands. Middle stages carry the extended product.
// The last stage is the output/accumulate register.
module pipe_mac_mul #(
  parameter int N      = 8,
  parameter int STAGES = 3,
  parameter int ACC_W  = 2*N+8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             signed_mode,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] p
);

  localparam int MID = STAGES - 2;
  localparam int PW  = 2*N;

  // Widen an operand to 2N bits, sign- or zero-extended by the beat's mode.
  // The low 2N bits of the widened product are then correct in both modes.
  function automatic logic signed [PW-1:0] widen_op(input logic [N-1:0] x,
                                                    input logic sgn);
    widen_op = {{N{sgn & x[N-1]}}, x};
  endfunction

  // Extend a 2N-bit product to the accumulator width.
  function automatic logic [ACC_W-1:0] extend_prod(input logic [PW-1:0] x,
                                                   input logic sgn);
    logic [ACC_W-1:0] r;
    r = '0;
    r[PW-1:0] = x;
    for (int i = PW; i < ACC_W; i++) r[i] = sgn & x[PW-1];
    return r;
  endfunction

  logic adv;
  logic vld_p0, sm_p0, ae_p0, ac_p0;
  logic [N-1:0] a_p0, b_p0;
  logic signed [PW-1:0] op_a_p0, op_b_p0, prod_p0;
  logic [ACC_W-1:0] ext_p0;

  logic [ACC_W-1:0] ext_q;
  logic vld_q, ae_q, ac_q;

  logic [ACC_W-1:0] acc, acc_sum, res;

  // The pipe moves only when the output register is free or being drained.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---- stage 1: input register ----
  // Stage 1 valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= in_valid;
  end

  // Stage 1 operand and per-beat mode capture.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p0  <= a;
      b_p0  <= b;
      sm_p0 <= signed_mode;
      ae_p0 <= acc_en;
      ac_p0 <= acc_clr;
    end
  end

  // Product of the stage 1 operands, extended to the accumulator width.
  always_comb begin
    op_a_p0 = widen_op(a_p0, sm_p0);
    op_b_p0 = widen_op(b_p0, sm_p0);
    prod_p0 = op_a_p0 * op_b_p0;
    ext_p0  = extend_prod(prod_p0, sm_p0);
  end

  // ---- stages 2..STAGES-1: product pipeline ----
  if (MID == 0) begin : g_direct
    assign ext_q = ext_p0;
    assign vld_q = vld_p0;
    assign ae_q  = ae_p0;
    assign ac_q  = ac_p0;
  end else begin : g_mid
    logic [ACC_W-1:0] ext_p1 [MID];
    logic [MID-1:0]   vld_p1, ae_p1, ac_p1;

    // Valid bits shift along the product stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p1 <= '0;
      else if (adv) begin
        vld_p1[0] <= vld_p0;
        for (int i = 1; i < MID; i++) vld_p1[i] <= vld_p1[i-1];
      end
    end

    // Extended product and accumulate controls shift with their valid bit.
    always_ff @(posedge clk) begin
      if (adv) begin
        ext_p1[0] <= ext_p0;
        ae_p1[0]  <= ae_p0;
        ac_p1[0]  <= ac_p0;
        for (int i = 1; i < MID; i++) begin
          ext_p1[i] <= ext_p1[i-1];
          ae_p1[i]  <= ae_p1[i-1];
          ac_p1[i]  <= ac_p1[i-1];
        end
      end
    end

    assign ext_q = ext_p1[MID-1];
    assign vld_q = vld_p1[MID-1];
    assign ae_q  = ae_p1[MID-1];
    assign ac_q  = ac_p1[MID-1];
  end

  // ---- stage STAGES: output / accumulate register ----
  // Select plain product or wrapped running sum. acc_clr only matters with acc_en.
  always_comb begin
    acc_sum = acc + ext_q;
    res     = (ae_q & ~ac_q) ? acc_sum : ext_q;
  end

  // Output register and accumulator. Bubbles leave both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= vld_q;
      if (vld_q) begin
        p <= res;
        if (ae_q) acc <= res;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mac_mul.sv
`timescale 1ns/1ps
// Scoreboard bench for pipe_mac_mul.
// Directed beats push their expected results into a queue.
// A monitor pops and compares on every output handshake.
module tb_pipe_mac_mul;
  localparam int N      = 8;
  localparam int STAGES = 3;
  localparam int ACC_W  = 2*N+8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [N-1:0]     a, b;
  logic             signed_mode, acc_en, acc_clr;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] p;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  pipe_mac_mul #(.N(N), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check_v(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Present one beat and hold it until accepted; queue its expected result.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic sm, input logic ae, input logic ac,
                      input logic [ACC_W-1:0] req);
    int n;
    logic ok;
    a = ta; b = tb; signed_mode = sm; acc_en = ae; acc_clr = ac;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end else begin
      exp_q.push_back(req);
    end
  endtask

  // Wait until every queued result has been seen, bounded.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: result scoreboard, output hold and in_ready behaviour.
  initial begin
    logic [ACC_W-1:0] prev_p;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      check_b("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_b("hold_valid", out_valid, 1'b1);
        check_v("hold_p", p, prev_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=%h required=none", p);
        end else begin
          check_v("result", p, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p = p;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] m;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_b("reset_out_valid", out_valid, 1'b0);
    check_v("reset_p", p, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_b("ready_after_reset", in_ready, 1'b1);

    // Unsigned 255*255 and its latency / single-cycle output.
    send(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, ACC_W'(24'h00FE01));
    in_valid = 1'b0;
    @(negedge clk); check_b("lat_0", out_valid, 1'b0);
    @(negedge clk); check_b("lat_1", out_valid, 1'b0);
    @(negedge clk); check_b("lat_2", out_valid, 1'b1);
    @(negedge clk); check_b("lat_3", out_valid, 1'b0);
    drain();

    // Signed versus unsigned on the same operands.
    send(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0, ACC_W'(24'hFFFFF1));
    send(8'hFD, 8'h05, 1'b0, 1'b0, 1'b0, ACC_W'(24'h0004F1));
    in_valid = 1'b0;
    drain();

    // MAC back-to-back: 12, 42, 4, 43.
    send(8'd3, 8'd4, 1'b0, 1'b1, 1'b1, ACC_W'(12));
    send(8'd5, 8'd6, 1'b0, 1'b1, 1'b0, ACC_W'(42));
    send(8'd2, 8'd2, 1'b0, 1'b0, 1'b1, ACC_W'(4));
    send(8'd1, 8'd1, 1'b0, 1'b1, 1'b0, ACC_W'(43));
    in_valid = 1'b0;
    drain();

    // Backpressure: 10-beat stream with out_ready low for 4 cycles.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(N'(i), N'(i+1), 1'b0, 1'b0, 1'b0, ACC_W'(i*(i+1)));
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check_b("stall_in_ready", in_ready, 1'b0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Accumulator wrap: 259 x 65025 = 16841475, mod 2^24 = 64259.
    m = '0;
    for (int k = 0; k < 259; k++) begin
      m = (k == 0) ? ACC_W'(65025) : m + ACC_W'(65025);
      send(8'd255, 8'd255, 1'b0, 1'b1, (k == 0),
           (k == 258) ? ACC_W'(64259) : m);
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-operation with accumulator at 42 and 2 beats in flight.
    send(8'd3, 8'd4, 1'b0, 1'b1, 1'b1, ACC_W'(12));
    send(8'd5, 8'd6, 1'b0, 1'b1, 1'b0, ACC_W'(42));
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(8'd7, 8'd7, 1'b0, 1'b1, 1'b0, ACC_W'(91));
    send(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, ACC_W'(1));
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_b("stalled_valid", out_valid, 1'b1);
    check_v("stalled_p", p, ACC_W'(91));
    rst = 1'b1;
    #1;
    check_b("async_rst_valid", out_valid, 1'b0);
    check_v("async_rst_p", p, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_b("ready_after_rst", in_ready, 1'b1);
    send(8'd2, 8'd3, 1'b0, 1'b1, 1'b0, ACC_W'(6));
    in_valid = 1'b0;
    drain();
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
